// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared widths, moduli, field type and mode enum for the time-of-day core
package clock_pkg;

    localparam int W       = 7;
    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HRS_MOD = 24;

    typedef logic [W-1:0] time_field_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        TSET = 2'd1,
        ASET = 2'd2
    } mode_t;

endpackage

// File: rtl/ct_mod_n.sv
// rtl/ct_mod_n.sv - enabled modulo-N counter with combinational wrap flag
//
// Ports:
//   Clk      in   rising-edge clock
//   Reset_n  in   asynchronous active-low reset, clears the count
//   en       in   advance by one on this edge
//   out      out  current count, always 0..N-1
//   wrap     out  en && out==N-1; the carry into the next stage
module ct_mod_n
    import clock_pkg::*;
#(
    parameter int N = 60
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        en,
    output time_field_t out,
    output logic        wrap
);

    logic at_top;

    // Compare against N-1 before incrementing so the count never reaches N.
    assign at_top = (out == time_field_t'(N - 1));
    assign wrap   = en && at_top;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out <= '0;
        end else if (en) begin
            out <= at_top ? '0 : out + time_field_t'(1);
        end
    end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 24-hour time-of-day counters, alarm registers, buzz flop and display mux
//
// Ports:
//   Clk, Reset_n            clock; asynchronous active-low reset
//   Pulse                   1 Hz one-cycle enable, the only event that moves counters
//   Timeset, Alarmset       mode levels, Timeset has priority
//   Minadv, Hrsadv          advance minutes/hours of the selected target on Pulse
//   Alarmon                 alarm armed
//   TSec, TMin, THrs        current time
//   AMin, AHrs              alarm time
//   Disp_Min, Disp_Hrs      alarm fields in alarm-set mode, otherwise time fields
//   Buzz                    registered alarm match output
module time_keeper
    import clock_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Pulse,
    input  logic        Timeset,
    input  logic        Alarmset,
    input  logic        Minadv,
    input  logic        Hrsadv,
    input  logic        Alarmon,
    output time_field_t TSec,
    output time_field_t TMin,
    output time_field_t THrs,
    output time_field_t AMin,
    output time_field_t AHrs,
    output time_field_t Disp_Min,
    output time_field_t Disp_Hrs,
    output logic        Buzz
);

    mode_t mode;

    always_comb begin
        mode = RUN;
        if (Timeset) begin
            mode = TSET;
        end else if (Alarmset) begin
            mode = ASET;
        end
    end

    logic sec_en, min_en, hrs_en, amin_en, ahrs_en;
    logic sec_wrap, min_wrap, hrs_wrap, amin_wrap, ahrs_wrap;

    // Seconds freeze during time-set; minutes/hours then step only on the
    // advance buttons with no carry between them.
    always_comb begin
        sec_en  = Pulse && (mode != TSET);
        min_en  = (mode == TSET) ? (Pulse && Minadv) : sec_wrap;
        hrs_en  = (mode == TSET) ? (Pulse && Hrsadv) : min_wrap;
        amin_en = Pulse && (mode == ASET) && Minadv;
        ahrs_en = Pulse && (mode == ASET) && Hrsadv;
    end

    ct_mod_n #(.N(SEC_MOD)) u_sec (
        .Clk(Clk), .Reset_n(Reset_n), .en(sec_en),  .out(TSec), .wrap(sec_wrap)
    );
    ct_mod_n #(.N(MIN_MOD)) u_min (
        .Clk(Clk), .Reset_n(Reset_n), .en(min_en),  .out(TMin), .wrap(min_wrap)
    );
    ct_mod_n #(.N(HRS_MOD)) u_hrs (
        .Clk(Clk), .Reset_n(Reset_n), .en(hrs_en),  .out(THrs), .wrap(hrs_wrap)
    );
    ct_mod_n #(.N(MIN_MOD)) u_amin (
        .Clk(Clk), .Reset_n(Reset_n), .en(amin_en), .out(AMin), .wrap(amin_wrap)
    );
    ct_mod_n #(.N(HRS_MOD)) u_ahrs (
        .Clk(Clk), .Reset_n(Reset_n), .en(ahrs_en), .out(AHrs), .wrap(ahrs_wrap)
    );

    // Top-of-chain carries have no consumer.
    logic unused_wraps;
    assign unused_wraps = &{1'b0, hrs_wrap, amin_wrap, ahrs_wrap};

    // Buzz follows the registered match, so it lags the match by one Clk.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Buzz <= 1'b0;
        end else begin
            Buzz <= Alarmon && (TMin == AMin) && (THrs == AHrs);
        end
    end

    assign Disp_Min = (mode == ASET) ? AMin : TMin;
    assign Disp_Hrs = (mode == ASET) ? AHrs : THrs;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed plus randomized bench for time_keeper against a seconds-of-day model
module tb_time_keeper;
    import clock_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n, Pulse, Timeset, Alarmset, Minadv, Hrsadv, Alarmon;
    time_field_t TSec, TMin, THrs, AMin, AHrs, Disp_Min, Disp_Hrs;
    logic Buzz;

    time_keeper dut (
        .Clk(Clk), .Reset_n(Reset_n), .Pulse(Pulse), .Timeset(Timeset),
        .Alarmset(Alarmset), .Minadv(Minadv), .Hrsadv(Hrsadv), .Alarmon(Alarmon),
        .TSec(TSec), .TMin(TMin), .THrs(THrs), .AMin(AMin), .AHrs(AHrs),
        .Disp_Min(Disp_Min), .Disp_Hrs(Disp_Hrs), .Buzz(Buzz)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: time of day as seconds since midnight, alarm as hour/minute.
    int  tsod = 0;
    int  amin_m = 0;
    int  ahrs_m = 0;
    bit  buzz_m = 0;
    bit  drv_ts = 0;
    bit  drv_as = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        assert (obs === 32'(exp)) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        int m, h;
        m = (tsod / 60) % 60;
        h = tsod / 3600;
        chk("tsec", 32'(TSec), tsod % 60);
        chk("tmin", 32'(TMin), m);
        chk("thrs", 32'(THrs), h);
        chk("amin", 32'(AMin), amin_m);
        chk("ahrs", 32'(AHrs), ahrs_m);
        chk("buzz", 32'(Buzz), int'(buzz_m));
        chk("disp_min", 32'(Disp_Min), (drv_as && !drv_ts) ? amin_m : m);
        chk("disp_hrs", 32'(Disp_Hrs), (drv_as && !drv_ts) ? ahrs_m : h);
    endtask

    task automatic tick(input bit p, input bit ts, input bit as_, input bit ma,
                        input bit ha, input bit ao);
        int h, m, s;
        Pulse = p; Timeset = ts; Alarmset = as_; Minadv = ma; Hrsadv = ha; Alarmon = ao;
        drv_ts = ts; drv_as = as_;
        @(posedge Clk);
        buzz_m = ao && ((tsod / 60) % 60 == amin_m) && (tsod / 3600 == ahrs_m);
        if (p) begin
            if (ts) begin
                h = tsod / 3600; m = (tsod / 60) % 60; s = tsod % 60;
                if (ma) m = (m + 1) % 60;
                if (ha) h = (h + 1) % 24;
                tsod = h * 3600 + m * 60 + s;
            end else begin
                tsod = (tsod + 1) % 86400;
                if (as_) begin
                    if (ma) amin_m = (amin_m + 1) % 60;
                    if (ha) ahrs_m = (ahrs_m + 1) % 24;
                end
            end
        end
        #1;
        chk_all();
    endtask

    // Reset asserted between edges; a Pulse held across an edge must be ignored.
    task automatic do_reset();
        Reset_n = 1'b0;
        Pulse = 1'b1; Timeset = 1'b0; Alarmset = 1'b0;
        Minadv = 1'b0; Hrsadv = 1'b0; Alarmon = 1'b0;
        drv_ts = 0; drv_as = 0;
        #2;
        tsod = 0; amin_m = 0; ahrs_m = 0; buzz_m = 0;
        chk_all();
        @(posedge Clk);
        #1;
        chk_all();
        Reset_n = 1'b1;
        Pulse = 1'b0;
    endtask

    int buzz_cnt;

    initial begin
        Reset_n = 1'b1;
        Pulse = 0; Timeset = 0; Alarmset = 0; Minadv = 0; Hrsadv = 0; Alarmon = 0;
        #1;
        do_reset();

        // 59 pulses then the minute carry
        for (int i = 0; i < 59; i++) tick(1, 0, 0, 0, 0, 0);
        chk("tsec_59", 32'(TSec), 59);
        chk("tmin_0", 32'(TMin), 0);
        tick(1, 0, 0, 0, 0, 0);
        chk("tsec_wrap", 32'(TSec), 0);
        chk("tmin_carry", 32'(TMin), 1);

        // Idle cycles and mode inputs without Pulse change nothing
        tick(0, 1, 0, 1, 1, 0);
        tick(0, 0, 1, 1, 1, 0);

        // Preload 23:59:58 and roll over midnight
        do_reset();
        for (int i = 0; i < 58; i++) tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 23; i++) tick(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 59; i++) tick(1, 1, 0, 1, 0, 0);
        chk("preload_sec", 32'(TSec), 58);
        tick(1, 0, 0, 0, 0, 0);
        chk("pre_midnight_sec", 32'(TSec), 59);
        tick(1, 0, 0, 0, 0, 0);
        chk("midnight_hrs", 32'(THrs), 0);
        chk("midnight_min", 32'(TMin), 0);
        chk("midnight_sec", 32'(TSec), 0);

        // Time-set: minute wrap without carry, then both fields at 23:59
        for (int i = 0; i < 59; i++) tick(1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 23; i++) tick(1, 1, 0, 0, 1, 0);
        tick(1, 1, 0, 1, 0, 0);
        chk("tset_min_wrap", 32'(TMin), 0);
        chk("tset_hrs_hold", 32'(THrs), 23);
        for (int i = 0; i < 59; i++) tick(1, 1, 0, 1, 0, 0);
        tick(1, 1, 0, 1, 1, 0);
        chk("tset_both_hrs", 32'(THrs), 0);
        chk("tset_both_min", 32'(TMin), 0);

        // Alarm-set to 07:30 while time runs, then display returns to time
        for (int i = 0; i < 7; i++) tick(1, 0, 1, 0, 1, 0);
        for (int i = 0; i < 30; i++) tick(1, 0, 1, 1, 0, 0);
        chk("disp_alarm_hrs", 32'(Disp_Hrs), 7);
        chk("disp_alarm_min", 32'(Disp_Min), 30);
        tick(1, 0, 0, 0, 0, 0);

        // Alarm 00:02 from reset: buzz for exactly one minute of pulses
        do_reset();
        tick(1, 0, 1, 1, 0, 0);
        tick(1, 0, 1, 1, 0, 0);
        buzz_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1, 0, 0, 0, 0, 1);
            if (Buzz === 1'b1) buzz_cnt++;
        end
        chk("buzz_len", 32'(buzz_cnt), 60);
        chk("buzz_after", 32'(Buzz), 0);

        // Alarm moved onto the current minute, then disarmed mid-minute
        tick(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0, 1);
        chk("buzz_on", 32'(Buzz), 1);
        tick(1, 0, 0, 0, 0, 0);
        chk("buzz_disarm", 32'(Buzz), 0);

        // Randomized mode/button/pulse mix
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(3) != 0), ($urandom_range(7) == 0), ($urandom_range(3) == 0),
                 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // Asynchronous reset at 12:34:56
        do_reset();
        for (int i = 0; i < 56; i++) tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 34; i++) tick(1, 1, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        chk("pre_reset_hrs", 32'(THrs), 12);
        chk("pre_reset_min", 32'(TMin), 34);
        chk("pre_reset_sec", 32'(TSec), 56);
        do_reset();
        tick(1, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
